lsu_rmw_ctrl: RTL and testbench



---
 rtl/lsu_rmw_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_rmw_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit front end for a word-wide data memory without byte enables.
// Sub-word loads are extracted and extended from the returned word; sub-word
// stores are done as a read of the old word followed by a merged full-word write.
module lsu_rmw_ctrl #(
  parameter int unsigned MEM_LATENCY    = 1,
  parameter bit          ERR_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  // The second-cycle datapath assumes read data arrives exactly one cycle later.
  if (MEM_LATENCY != 1) begin : g_latency_check
    $error("lsu_rmw_ctrl only supports MEM_LATENCY == 1");
  end

  localparam logic [2:0] SizeB  = 3'b000;
  localparam logic [2:0] SizeH  = 3'b001;
  localparam logic [2:0] SizeW  = 3'b010;
  localparam logic [2:0] SizeBu = 3'b100;
  localparam logic [2:0] SizeHu = 3'b101;

  typedef enum logic [1:0] {StIdle, StLoad, StRmw} state_e;

  state_e      state_q, state_d;
  logic [29:0] waddr_q;
  logic [2:0]  size_q;
  logic [15:0] wd_q;
  logic [1:0]  off_q;
  logic        latch_en;

  logic        req_legal;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merge_data;
  logic [31:0] merged_word;

  // Decode whether the incoming request has a legal size and natural alignment.
  always_comb begin
    req_legal = 1'b0;
    unique case (core_size_i)
      SizeB, SizeBu: req_legal = 1'b1;
      SizeH, SizeHu: req_legal = ~core_addr_i[0];
      SizeW:         req_legal = (core_addr_i[1:0] == 2'b00);
      default:       req_legal = 1'b0;
    endcase
  end

  // Extract and extend the addressed lane of the returned word for loads.
  always_comb begin
    rd_shift = mem_rd_i >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    unique case (size_q)
      SizeB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      SizeH:   load_val = {{16{rd_half[15]}}, rd_half};
      SizeBu:  load_val = {24'h0, rd_byte};
      SizeHu:  load_val = {16'h0, rd_half};
      default: load_val = mem_rd_i;
    endcase
  end

  // Replace the stored lane of the old word with the latched store data.
  always_comb begin
    if (size_q[0]) begin
      lane_mask  = 32'h0000_ffff << {off_q[1], 4'b0000};
      merge_data = {2{wd_q}};
    end else begin
      lane_mask  = 32'h0000_00ff << {off_q, 3'b000};
      merge_data = {4{wd_q[7:0]}};
    end
    merged_word = (mem_rd_i & ~lane_mask) | (merge_data & lane_mask);
  end

  // Next state and combinational outputs; reset forces every output low.
  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    core_rd_o    = 32'h0;
    core_stall_o = 1'b0;
    err_o        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wd_o     = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (core_req_i) begin
          latch_en = 1'b1;
          if (!req_legal) begin
            err_o = ERR_ON_ILLEGAL;
          end else if (core_we_i && (core_size_i == SizeW)) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {core_addr_i[31:2], 2'b00};
            mem_wd_o   = core_wd_i;
          end else begin
            // Loads and sub-word stores both start by reading the word.
            mem_req_o    = 1'b1;
            mem_addr_o   = {core_addr_i[31:2], 2'b00};
            core_stall_o = 1'b1;
            state_d      = core_we_i ? StRmw : StLoad;
          end
        end
      end
      StLoad: begin
        core_rd_o = load_val;
        state_d   = StIdle;
      end
      StRmw: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {waddr_q, 2'b00};
        mem_wd_o   = merged_word;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (rst_i) begin
      core_rd_o    = 32'h0;
      core_stall_o = 1'b0;
      err_o        = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = 32'h0;
      mem_wd_o     = 32'h0;
    end
  end

  // State register and request field latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      waddr_q <= 30'h0;
      size_q  <= 3'b000;
      wd_q    <= 16'h0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        waddr_q <= core_addr_i[31:2];
        size_q  <= core_size_i;
        wd_q    <= core_wd_i[15:0];
        off_q   <= core_addr_i[1:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a reference memory model and per-cycle
// output comparison.
module tb_lsu_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] e_rd, e_addr, e_wd;
  logic        e_stall, e_err, e_req, e_we;

  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];

  lsu_rmw_ctrl #(
    .MEM_LATENCY   (1),
    .ERR_ON_ILLEGAL(1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_size_i (core_size_i),
    .core_addr_i (core_addr_i),
    .core_wd_i   (core_wd_i),
    .core_rd_o   (core_rd_o),
    .core_stall_o(core_stall_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i)
  );

  always #5 clk = ~clk;

  // Data memory environment: one-cycle registered read, full-word write.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) dmem[mem_addr_o[11:2]] <= mem_wd_o;
      else          mem_rd_i <= dmem[mem_addr_o[11:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model expectation.
  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      chk("core_rd",    core_rd_o,           e_rd);
      chk("core_stall", {31'h0, core_stall_o}, {31'h0, e_stall});
      chk("err",        {31'h0, err_o},      {31'h0, e_err});
      chk("mem_req",    {31'h0, mem_req_o},  {31'h0, e_req});
      chk("mem_we",     {31'h0, mem_we_o},   {31'h0, e_we});
      chk("mem_addr",   mem_addr_o,          e_addr);
      chk("mem_wd",     mem_wd_o,            e_wd);
    end
  end

  function automatic bit is_legal(input logic [2:0] sz, input logic [31:0] a);
    int off = int'(a[1:0]);
    if (sz == 3'b000 || sz == 3'b100) return 1'b1;
    if (sz == 3'b001 || sz == 3'b101) return (off % 2) == 0;
    if (sz == 3'b010) return off == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] sz, input logic [31:0] w,
                                         input int off);
    logic [31:0] s = w >> (8 * off);
    case (sz)
      3'b000:  return (s[7] ? 32'hFFFF_FF00 : 32'h0) | (s & 32'hFF);
      3'b001:  return (s[15] ? 32'hFFFF_0000 : 32'h0) | (s & 32'hFFFF);
      3'b100:  return s & 32'hFF;
      3'b101:  return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_word(input logic [2:0] sz, input logic [31:0] old,
                                          input int off, input logic [31:0] d);
    logic [31:0] m = ((sz == 3'b000) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (old & ~m) | ((d << (8 * off)) & m);
  endfunction

  task automatic set_exp(input logic [31:0] rd, input logic st, input logic er,
                         input logic rq, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd);
    e_rd = rd; e_stall = st; e_err = er; e_req = rq; e_we = we; e_addr = ad; e_wd = wd;
  endtask

  task automatic cyc_idle(input logic rst);
    @(negedge clk);
    rst_i = rst; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
    core_addr_i = 32'h0; core_wd_i = 32'h0;
    set_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One core access; second-cycle core inputs are scrambled since they must be ignored.
  task automatic do_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit rst2, input bit pin,
                       input logic [31:0] lit);
    logic [31:0] wa = {a[31:2], 2'b00};
    int          ix = int'(a[11:2]);
    int          off = int'(a[1:0]);
    logic [31:0] v;
    @(negedge clk);
    rst_i = 1'b0; core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
    core_addr_i = a; core_wd_i = d;
    if (!is_legal(sz, a)) begin
      set_exp(32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end else if (we && sz == 3'b010) begin
      set_exp(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, wa, d);
      ref_mem[ix] = d;
      if (pin) begin #3; chk("pin_sw_wd", mem_wd_o, lit); end
    end else begin
      set_exp(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, wa, 32'h0);
      @(negedge clk);
      rst_i = rst2; core_addr_i = ~a; core_wd_i = ~d; core_size_i = 3'b111;
      core_we_i = ~we;
      if (rst2) begin
        set_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (!we) begin
        v = ld_val(sz, ref_mem[ix], off);
        set_exp(v, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if (pin) begin #3; chk("pin_load", core_rd_o, lit); end
      end else begin
        v = st_word(sz, ref_mem[ix], off, d);
        set_exp(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, wa, v);
        ref_mem[ix] = v;
        if (pin) begin #3; chk("pin_rmw_wd", mem_wd_o, lit); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    dmem[32'h100 >> 2] = 32'h8899AABB; ref_mem[32'h100 >> 2] = 32'h8899AABB;
    dmem[32'h300 >> 2] = 32'h11223344; ref_mem[32'h300 >> 2] = 32'h11223344;
    dmem[32'h500 >> 2] = 32'h55667788; ref_mem[32'h500 >> 2] = 32'h55667788;

    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
    core_addr_i = 32'h0; core_wd_i = 32'h0;
    set_exp(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_en = 1'b1;
    cyc_idle(1'b1);
    cyc_idle(1'b1);
    cyc_idle(1'b0);

    // Sub-word loads from 0x8899AABB
    do_op(1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 1'b1, 32'hFFFFFFAA);
    do_op(1'b0, 3'b100, 32'h101, 32'h0, 1'b0, 1'b1, 32'h000000AA);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 1'b1, 32'hFFFF8899);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 1'b1, 32'h00008899);
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1'b1, 32'hFFFFFF88);
    do_op(1'b0, 3'b001, 32'h100, 32'h0, 1'b0, 1'b1, 32'hFFFFAABB);
    do_op(1'b0, 3'b100, 32'h100, 32'h0, 1'b0, 1'b1, 32'h000000BB);
    cyc_idle(1'b0);

    // Full-word store then load back
    do_op(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    cyc_idle(1'b0);

    // Read-modify-write stores on 0x11223344
    do_op(1'b1, 3'b000, 32'h303, 32'h000000AB, 1'b0, 1'b1, 32'hAB223344);
    do_op(1'b1, 3'b001, 32'h300, 32'h0000CDEF, 1'b0, 1'b1, 32'hAB22CDEF);
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 1'b1, 32'hAB22CDEF);
    do_op(1'b1, 3'b001, 32'h302, 32'hFFFF1234, 1'b0, 1'b1, 32'h1234CDEF);
    cyc_idle(1'b0);

    // Misaligned and illegal requests
    do_op(1'b0, 3'b010, 32'h402, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc_idle(1'b0);
    do_op(1'b1, 3'b001, 32'h401, 32'h1234, 1'b0, 1'b0, 32'h0);
    cyc_idle(1'b0);
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc_idle(1'b0);
    do_op(1'b0, 3'b101, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc_idle(1'b0);

    // Reset during the RMW write cycle suppresses the write
    do_op(1'b1, 3'b000, 32'h500, 32'h000000EE, 1'b1, 1'b0, 32'h0);
    cyc_idle(1'b0);
    do_op(1'b0, 3'b010, 32'h500, 32'h0, 1'b0, 1'b1, 32'h55667788);

    // Back-to-back load, sub-word store, load
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h8899AABB);
    do_op(1'b1, 3'b000, 32'h100, 32'h0000005A, 1'b0, 1'b1, 32'h8899AA5A);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b1, 32'h8899AA5A);
    cyc_idle(1'b0);
    cyc_idle(1'b0);
    @(negedge clk);
    #5;
    chk_en = 1'b0;

    // Memory contents left behind by the DUT versus the model
    chk("mem_0x100", dmem[32'h100 >> 2], ref_mem[32'h100 >> 2]);
    chk("mem_0x200", dmem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
    chk("mem_0x300", dmem[32'h300 >> 2], ref_mem[32'h300 >> 2]);
    chk("mem_0x500", dmem[32'h500 >> 2], 32'h55667788);
    chk("mem_0x400", dmem[32'h400 >> 2], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
